// File: rtl/toy_stdin_rx.sv
// 8N1 UART receiver pairing bytes big-endian into 16-bit words behind a fall-through FIFO.
// Word visible 2 cycles after the low byte's stop sample; full FIFO drops the word and pulses overrun_o.
module toy_stdin_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  input  logic                          flush_i,
  output logic                          out_val_o,
  output logic [15:0]                   out_data_o,
  input  logic                          out_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  logic          rx_meta_q, rx_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err_q, frame_err_d;
  logic          stop_bad;
  logic          hi_pend_q, hi_pend_d;
  logic [7:0]    hi_q, hi_d;
  logic          push_q, push_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          pop, full, wr_en;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    stop_bad    = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Mid-start-bit recheck rejects glitches shorter than half a bit.
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            stop_bad    = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        bit_cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi_pend_d = hi_pend_q;
    hi_d      = hi_q;
    word_d    = word_q;
    push_d    = 1'b0;
    if (flush_i || stop_bad) begin
      hi_pend_d = 1'b0;
    end else if (byte_vld_q) begin
      if (hi_pend_q) begin
        word_d    = {hi_q, byte_q};
        push_d    = 1'b1;
        hi_pend_d = 1'b0;
      end else begin
        hi_d      = byte_q;
        hi_pend_d = 1'b1;
      end
    end
  end

  assign pop   = out_val_o & out_rdy_i;
  assign full  = (level_q == DEPTH);
  assign wr_en = push_q & (~full | pop);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      overrun_d = push_q & full & ~pop;
      if (wr_en) begin
        mem_d[wr_ptr_q] = word_q;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   level_d = level_q + (PW+1)'(1);
        2'b01:   level_d = level_q - (PW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      hi_pend_q   <= 1'b0;
      hi_q        <= '0;
      push_q      <= 1'b0;
      word_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      hi_pend_q   <= hi_pend_d;
      hi_q        <= hi_d;
      push_q      <= push_d;
      word_q      <= word_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_val_o   = (level_q != '0);
  assign out_data_o  = out_val_o ? mem_q[rd_ptr_q] : 16'h0000;
  assign level_o     = level_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
